// File: rtl/port_alloc_rr_if.sv
// Switch-allocation bus between the router pipeline and port_alloc_rr.
// The upstream side drives flit requests and free ports; the allocator returns registered grants.
interface port_alloc_rr_if #(
   parameter int NUM_PORT = 5,
   parameter int NUM_FLIT = 4,
   parameter int CNT_W    = 16,
   parameter int PTR_W    = $clog2(NUM_FLIT)
);
   logic [NUM_FLIT-1:0]          in_valid;
   logic [NUM_FLIT*NUM_PORT-1:0] in_req;
   logic [NUM_PORT-1:0]          avail;
   logic                         mode;
   logic [NUM_FLIT-1:0]          out_valid;
   logic [NUM_FLIT*NUM_PORT-1:0] out_alloc;
   logic [NUM_FLIT-1:0]          out_deflect;
   logic [NUM_FLIT-1:0]          out_stall;
   logic [NUM_PORT-1:0]          remain;
   logic [PTR_W-1:0]             prio_ptr;
   logic [CNT_W-1:0]             defl_cnt;

   modport master (
      output in_valid, in_req, avail, mode,
      input  out_valid, out_alloc, out_deflect, out_stall, remain, prio_ptr, defl_cnt
   );

   modport slave (
      input  in_valid, in_req, avail, mode,
      output out_valid, out_alloc, out_deflect, out_stall, remain, prio_ptr, defl_cnt
   );
endinterface

// File: rtl/port_alloc_rr.sv
// Multi-flit output-port allocator: rotating-priority productive pass, then an optional
// deflection pass over the leftover ports; results registered one cycle later.
module port_alloc_rr #(
   parameter int NUM_PORT = 5,
   parameter int NUM_FLIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   port_alloc_rr_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_FLIT);
   localparam int PC_W  = $clog2(NUM_FLIT + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [NUM_FLIT-1:0]          out_valid_reg, out_deflect_reg, out_stall_reg;
   logic [NUM_FLIT*NUM_PORT-1:0] out_alloc_reg;
   logic [NUM_PORT-1:0]          remain_reg;
   logic [PTR_W-1:0]             prio_ptr_reg;
   logic [CNT_W-1:0]             defl_cnt_reg;

   logic [NUM_FLIT*NUM_PORT-1:0] alloc_next;
   logic [NUM_FLIT-1:0]          defl_next, stall_next, served;
   logic [NUM_PORT-1:0]          free_v, cand, pick;
   logic [PTR_W-1:0]             flit_idx;
   logic [PTR_W-1:0]             prio_ptr_next;
   logic [PC_W-1:0]              defl_pop;
   logic [SUM_W-1:0]             cnt_sum;
   logic [CNT_W-1:0]             defl_cnt_next;

   function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_FLIT) s = s - NUM_FLIT;
      return PTR_W'(s);
   endfunction

   // Productive pass must finish for every flit before any deflection is handed out.
   always_comb begin
      free_v     = bus.avail;
      alloc_next = '0;
      defl_next  = '0;
      served     = '0;
      cand       = '0;
      pick       = '0;
      flit_idx   = '0;
      for (int k = 0; k < NUM_FLIT; k++) begin
         flit_idx = rot_idx(prio_ptr_reg, k);
         cand     = bus.in_req[flit_idx*NUM_PORT +: NUM_PORT] & free_v;
         pick     = cand & (~cand + NUM_PORT'(1));
         if (bus.in_valid[flit_idx] && cand != '0) begin
            alloc_next[flit_idx*NUM_PORT +: NUM_PORT] = pick;
            free_v           = free_v & ~pick;
            served[flit_idx] = 1'b1;
         end
      end
      if (bus.mode) begin
         for (int k = 0; k < NUM_FLIT; k++) begin
            flit_idx = rot_idx(prio_ptr_reg, k);
            cand     = free_v;
            pick     = cand & (~cand + NUM_PORT'(1));
            if (bus.in_valid[flit_idx] && !served[flit_idx] && cand != '0) begin
               alloc_next[flit_idx*NUM_PORT +: NUM_PORT] = pick;
               free_v              = free_v & ~pick;
               served[flit_idx]    = 1'b1;
               defl_next[flit_idx] = 1'b1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FLIT; gi++) begin : g_stall
         assign stall_next[gi] = bus.in_valid[gi] & ~served[gi];
      end
   endgenerate

   always_comb begin
      defl_pop = '0;
      for (int i = 0; i < NUM_FLIT; i++) begin
         defl_pop = defl_pop + PC_W'(defl_next[i]);
      end
      cnt_sum       = SUM_W'(defl_cnt_reg) + SUM_W'(defl_pop);
      defl_cnt_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      prio_ptr_next = prio_ptr_reg;
      if (|bus.in_valid) begin
         prio_ptr_next = (prio_ptr_reg == PTR_W'(NUM_FLIT - 1)) ? '0 : prio_ptr_reg + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_reg   <= '0;
         out_alloc_reg   <= '0;
         out_deflect_reg <= '0;
         out_stall_reg   <= '0;
         remain_reg      <= '0;
         prio_ptr_reg    <= '0;
         defl_cnt_reg    <= '0;
      end else begin
         out_valid_reg   <= bus.in_valid;
         out_alloc_reg   <= alloc_next;
         out_deflect_reg <= defl_next;
         out_stall_reg   <= stall_next;
         remain_reg      <= free_v;
         prio_ptr_reg    <= prio_ptr_next;
         defl_cnt_reg    <= defl_cnt_next;
      end
   end

   assign bus.out_valid   = out_valid_reg;
   assign bus.out_alloc   = out_alloc_reg;
   assign bus.out_deflect = out_deflect_reg;
   assign bus.out_stall   = out_stall_reg;
   assign bus.remain      = remain_reg;
   assign bus.prio_ptr    = prio_ptr_reg;
   assign bus.defl_cnt    = defl_cnt_reg;
endmodule
